// File: rtl/bcd_display_mux.sv
// ---------------------------------------------------------------------------
// bcd_display_mux
//
// Multiplexed seven-segment driver for the frequency counter. On a latch
// strobe it captures the cascaded BCD digits and the top-digit carry from the
// bcdCount chain into a shadow register. It then scans the captured digits
// onto a common-anode display, one digit at a time.
//
// Parameters
//   DIGITS      : number of BCD digits scanned (>= 2)
//   REFRESH_DIV : clock cycles each digit stays lit (>= 1)
//
// Ports
//   clk      : system clock, all state rising-edge triggered
//   reset    : asynchronous active-low reset
//   latch    : single-cycle capture strobe (end of gate window)
//   bcd_in   : DIGITS BCD nibbles, nibble 0 is least significant
//   overflow : carry out of the top bcdCount digit
//   seg      : active-low segments, seg[0]=a ... seg[6]=g (registered)
//   dp       : active-low decimal point, overflow marker on the top digit
//   an       : active-low one-hot digit enables (registered)
//
// Optional feature
//   BCD_DISPLAY_LZB_EN : when defined, leading zeros above digit 0 are blanked.
// ---------------------------------------------------------------------------
module bcd_display_mux #(
  parameter int DIGITS      = 4,
  parameter int REFRESH_DIV = 50000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  latch,
  input  logic [4*DIGITS-1:0]   bcd_in,
  input  logic                  overflow,
  output logic [6:0]            seg,
  output logic                  dp,
  output logic [DIGITS-1:0]     an
);

  localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IW = $clog2(DIGITS);
  localparam logic [CW-1:0] LP_TERMINAL = CW'(REFRESH_DIV - 1);
  localparam logic [IW-1:0] LP_LAST_IDX = IW'(DIGITS - 1);
  localparam logic [DIGITS-1:0] LP_ONE  = {{(DIGITS-1){1'b0}}, 1'b1};

  logic [4*DIGITS-1:0] r_shadow;
  logic                r_shadowOvf;
  logic [CW-1:0]       r_refreshCnt;
  logic [IW-1:0]       r_digitIdx;
  logic [6:0]          r_seg;
  logic                r_dp;
  logic [DIGITS-1:0]   r_an;

  logic                w_terminal;
  logic [3:0]          w_nibble;
  logic [6:0]          w_segDecoded;
  logic [6:0]          w_segNext;
  logic                w_dpNext;
  logic [DIGITS-1:0]   w_anNext;

  // Shadow register: only a latch strobe lets new counter data through, so
  // the display stays stable while the counter chain keeps counting.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_shadow    <= '0;
      r_shadowOvf <= 1'b0;
    end else if (latch) begin
      r_shadow    <= bcd_in;
      r_shadowOvf <= overflow;
    end
  end

  assign w_terminal = (r_refreshCnt == LP_TERMINAL);

  // Refresh counter and digit index. The index only moves on the last cycle
  // of a dwell period, so every digit is lit for exactly REFRESH_DIV cycles.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_refreshCnt <= '0;
      r_digitIdx   <= '0;
    end else if (w_terminal) begin
      r_refreshCnt <= '0;
      r_digitIdx   <= (r_digitIdx == LP_LAST_IDX) ? '0 : r_digitIdx + 1'b1;
    end else begin
      r_refreshCnt <= r_refreshCnt + 1'b1;
    end
  end

  assign w_nibble = r_shadow[4*r_digitIdx +: 4];

  // Seven-segment decode of the indexed nibble; non-BCD values show a dash
  // so a corrupted count is visibly wrong rather than misread as a number.
  always_comb begin
    w_segDecoded = 7'b0111111;
    case (w_nibble)
      4'd0:    w_segDecoded = 7'b1000000;
      4'd1:    w_segDecoded = 7'b1111001;
      4'd2:    w_segDecoded = 7'b0100100;
      4'd3:    w_segDecoded = 7'b0110000;
      4'd4:    w_segDecoded = 7'b0011001;
      4'd5:    w_segDecoded = 7'b0010010;
      4'd6:    w_segDecoded = 7'b0000010;
      4'd7:    w_segDecoded = 7'b1111000;
      4'd8:    w_segDecoded = 7'b0000000;
      4'd9:    w_segDecoded = 7'b0010000;
      default: w_segDecoded = 7'b0111111;
    endcase
  end

`ifdef BCD_DISPLAY_LZB_EN
  logic [4*DIGITS-1:0] w_upperNibbles;
  logic                w_blank;

  // A digit is a leading zero when it and every more significant nibble are
  // zero. Shifting the indexed nibble down to bit 0 leaves exactly that set.
  always_comb begin
    w_upperNibbles = r_shadow >> (4 * r_digitIdx);
    w_blank        = (r_digitIdx != '0) && (w_upperNibbles == '0);
  end

  assign w_segNext = w_blank ? 7'h7F : w_segDecoded;
`else
  assign w_segNext = w_segDecoded;
`endif

  assign w_anNext = ~(LP_ONE << r_digitIdx);
  assign w_dpNext = ~((r_digitIdx == LP_LAST_IDX) && r_shadowOvf);

  // Output registers: pins reflect index and shadow one cycle later, which
  // keeps the pad drivers glitch-free and the single-low enable guaranteed.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_seg <= 7'h7F;
      r_dp  <= 1'b1;
      r_an  <= '1;
    end else begin
      r_seg <= w_segNext;
      r_dp  <= w_dpNext;
      r_an  <= w_anNext;
    end
  end

  assign seg = r_seg;
  assign dp  = r_dp;
  assign an  = r_an;

endmodule

// File: tb/tb_bcd_display_mux.sv
// ---------------------------------------------------------------------------
// tb_bcd_display_mux
//
// Self-checking bench for bcd_display_mux with DIGITS=4, REFRESH_DIV=4.
// A behavioural model derives the scan position from the number of clock
// edges since reset and decodes a table lookup of the latched value; a
// compare process checks every falling edge. Directed literal checks pin
// the model at hand-computed points of the scan.
// ---------------------------------------------------------------------------
module tb_bcd_display_mux;

  localparam int DIGITS      = 4;
  localparam int REFRESH_DIV = 4;

`ifdef BCD_DISPLAY_LZB_EN
  localparam logic [6:0] ZERO_HI = 7'h7F;
`else
  localparam logic [6:0] ZERO_HI = 7'h40;
`endif

  logic                clk;
  logic                reset;
  logic                latch;
  logic [4*DIGITS-1:0] bcd_in;
  logic                overflow;
  logic [6:0]          seg;
  logic                dp;
  logic [DIGITS-1:0]   an;

  int nVectors     = 0;
  int nMiscompares = 0;
  bit checkEn      = 1'b0;

  logic [6:0] segTab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12,
                              7'h02, 7'h78, 7'h00, 7'h10, 7'h3F, 7'h3F,
                              7'h3F, 7'h3F, 7'h3F, 7'h3F};

  int                  mEdges;
  logic [4*DIGITS-1:0] mShadow;
  logic                mOvf;
  logic [6:0]          expSeg;
  logic                expDp;
  logic [DIGITS-1:0]   expAn;

  bcd_display_mux #(
    .DIGITS      (DIGITS),
    .REFRESH_DIV (REFRESH_DIV)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .latch    (latch),
    .bcd_in   (bcd_in),
    .overflow (overflow),
    .seg      (seg),
    .dp       (dp),
    .an       (an)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: the digit shown after an edge is the one indexed by the edge count
  // before it, using the shadow value held before that edge.
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      mEdges  <= 0;
      mShadow <= '0;
      mOvf    <= 1'b0;
      expSeg  <= 7'h7F;
      expDp   <= 1'b1;
      expAn   <= '1;
    end else begin
      int idx;
      logic [4*DIGITS-1:0] upper;
      idx   = (mEdges / REFRESH_DIV) % DIGITS;
      upper = mShadow >> (4 * idx);
      expAn <= ~(DIGITS'(1) << idx);
      expDp <= !(idx == DIGITS - 1 && mOvf);
`ifdef BCD_DISPLAY_LZB_EN
      if (idx > 0 && upper == 0) expSeg <= 7'h7F;
      else                       expSeg <= segTab[upper[3:0]];
`else
      expSeg <= segTab[upper[3:0]];
`endif
      if (latch) begin
        mShadow <= bcd_in;
        mOvf    <= overflow;
      end
      mEdges <= mEdges + 1;
    end
  end

  task automatic checkOutput(input string name, input logic [DIGITS-1:0] wantAn,
                             input logic [6:0] wantSeg, input logic wantDp);
    nVectors++;
    if (an !== wantAn || seg !== wantSeg || dp !== wantDp) begin
      nMiscompares++;
      $display("[TB] FAIL %s: an=%b seg=%b dp=%b, want an=%b seg=%b dp=%b",
               name, an, seg, dp, wantAn, wantSeg, wantDp);
    end
  endtask

  // Compare process: checks against the model on every falling edge.
  always @(negedge clk) begin
    if (checkEn) checkOutput("model", expAn, expSeg, expDp);
  end

  // Advance to the falling edge after the k-th rising edge since reset.
  task automatic applyStimulus(input int k);
    int guard;
    guard = 0;
    while (mEdges < k && guard < 1000) begin
      @(negedge clk);
      guard++;
    end
    if (mEdges < k) begin
      nVectors++;
      nMiscompares++;
      $display("[TB] FAIL edge_wait: reached %0d, want %0d", mEdges, k);
    end
  endtask

  initial begin
    reset    = 1'b0;
    latch    = 1'b0;
    bcd_in   = '0;
    overflow = 1'b0;
    @(negedge clk);
    checkEn = 1'b1;
    @(negedge clk);
    checkOutput("reset_hold", 4'b1111, 7'h7F, 1'b1);

    // Release reset and latch 1234 on the very first edge.
    reset  = 1'b1;
    latch  = 1'b1;
    bcd_in = 16'h1234;
    applyStimulus(1);
    latch = 1'b0;
    checkOutput("post_reset", 4'b1110, 7'h40, 1'b1);
    applyStimulus(2);  checkOutput("scan_d0", 4'b1110, 7'h19, 1'b1);
    applyStimulus(5);  checkOutput("scan_d1", 4'b1101, 7'h30, 1'b1);
    applyStimulus(9);  checkOutput("scan_d2", 4'b1011, 7'h24, 1'b1);
    applyStimulus(13); checkOutput("scan_d3", 4'b0111, 7'h79, 1'b1);
    applyStimulus(17); checkOutput("scan_wrap", 4'b1110, 7'h19, 1'b1);

    // Input changes without a latch must stay invisible.
    bcd_in = 16'h9999;
    applyStimulus(49); checkOutput("hold", 4'b1110, 7'h19, 1'b1);
    latch = 1'b1;
    applyStimulus(50);
    latch = 1'b0;
    checkOutput("latch_edge", 4'b1110, 7'h19, 1'b1);
    applyStimulus(51); checkOutput("latch_next", 4'b1110, 7'h10, 1'b1);

    // Invalid nibbles and overflow marker.
    latch    = 1'b1;
    bcd_in   = 16'h00AF;
    overflow = 1'b1;
    applyStimulus(52);
    latch = 1'b0;
    applyStimulus(53); checkOutput("dash_d1", 4'b1101, 7'h3F, 1'b1);
    applyStimulus(61); checkOutput("ovf_dp", 4'b0111, ZERO_HI, 1'b0);
    applyStimulus(65); checkOutput("dash_d0", 4'b1110, 7'h3F, 1'b1);
    latch    = 1'b1;
    overflow = 1'b0;
    applyStimulus(66);
    latch = 1'b0;
    applyStimulus(77); checkOutput("ovf_clear", 4'b0111, ZERO_HI, 1'b1);

    // Leading zeros.
    latch  = 1'b1;
    bcd_in = 16'h0050;
    applyStimulus(78);
    latch = 1'b0;
    applyStimulus(80); checkOutput("lz_d3", 4'b0111, ZERO_HI, 1'b1);
    applyStimulus(81); checkOutput("lz_d0", 4'b1110, 7'h40, 1'b1);
    applyStimulus(85); checkOutput("lz_d1", 4'b1101, 7'h12, 1'b1);
    applyStimulus(89); checkOutput("lz_d2", 4'b1011, ZERO_HI, 1'b1);
    latch  = 1'b1;
    bcd_in = 16'h0000;
    applyStimulus(90);
    latch = 1'b0;
    applyStimulus(93); checkOutput("zero_d3", 4'b0111, ZERO_HI, 1'b1);
    applyStimulus(97); checkOutput("zero_d0", 4'b1110, 7'h40, 1'b1);

    // Latch on a terminal-count edge.
    applyStimulus(99);
    latch  = 1'b1;
    bcd_in = 16'h5678;
    applyStimulus(100);
    latch = 1'b0;
    checkOutput("tc_latch_edge", 4'b1110, 7'h40, 1'b1);
    applyStimulus(101); checkOutput("tc_latch_next", 4'b1101, 7'h78, 1'b1);

    // Reset in the middle of a scan.
    applyStimulus(107); checkOutput("pre_reset_d2", 4'b1011, 7'h02, 1'b1);
    #2 reset = 1'b0;
    #1 checkOutput("async_reset", 4'b1111, 7'h7F, 1'b1);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    applyStimulus(1); checkOutput("restart_d0", 4'b1110, 7'h40, 1'b1);
    applyStimulus(5); checkOutput("restart_d1", 4'b1101, ZERO_HI, 1'b1);
    applyStimulus(8);

    checkEn = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
    $finish;
  end

endmodule
